// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter.
//   arb_state_e     : arbiter FSM state (IDLE, OWN0, OWN1)
//   OWNER0 / OWNER1 : encoding of the last_owner register
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;

endpackage

// File: rtl/mux2_w.sv
// DW-wide combinational 2:1 mux.
//   in0, in1 : data inputs
//   sel      : 0 selects in0, 1 selects in1
//   out      : selected data
module mux2_w #(
    parameter int DW = 1
) (
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic          sel,
    output logic [DW-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 mux lane.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   req0, req1   : lane requests
//   din0, din1   : requester data
//   gnt0, gnt1   : registered grants, decoded from FSM state
//   sel          : registered mux select (1 = requester 1), held in IDLE
//   dout         : registered mux output, updated only while a grant is live
//   dout_vld     : dout carries data sampled during a grant cycle
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          sel,
    output logic [DW-1:0] dout,
    output logic          dout_vld
);

    localparam int             CW      = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_HOLD - 1);

    arb_state_e     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           last_owner, last_owner_nxt;
    logic           sel_nxt;
    logic [DW-1:0]  mux_out;

    // Next-state logic. A saturated counter only matters when the other
    // side is also requesting; uncontested ownership never times out.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = (last_owner == OWNER1) ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_nxt = req1 ? OWN1 : IDLE;
                else if (req1 && cnt == CNT_MAX)
                    state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_nxt = req0 ? OWN0 : IDLE;
                else if (req0 && cnt == CNT_MAX)
                    state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold counter, owner history and select follow the next state so they
    // line up with the registered grant.
    always_comb begin
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        sel_nxt        = sel;
        if (state_nxt == IDLE) begin
            cnt_nxt = '0;
        end else if (state_nxt != state) begin
            cnt_nxt        = '0;
            last_owner_nxt = (state_nxt == OWN1) ? OWNER1 : OWNER0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
        end
        if (state_nxt == OWN0)
            sel_nxt = 1'b0;
        else if (state_nxt == OWN1)
            sel_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= OWNER1;
            sel        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
            sel        <= sel_nxt;
        end
    end

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    mux2_w #(.DW(DW)) u_mux (
        .in0 (din0),
        .in1 (din1),
        .sel (sel),
        .out (mux_out)
    );

    // Data is captured in the grant cycle and presented one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            if (gnt0 || gnt1)
                dout <= mux_out;
            dout_vld <= gnt0 || gnt1;
        end
    end

endmodule
